// File: rtl/arm_dcache.sv
// 2-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller, with saturating hit/miss counters.
module arm_dcache #(
  parameter int SET_BITS  = 6,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS - 3;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t r_state, w_next;

  logic [1:0]       r_valid [SETS];
  logic [SETS-1:0]  r_lru;
  logic [TAG_W-1:0] r_tag   [2][SETS];
  logic [63:0]      r_data  [2][SETS];

  logic [ADDR_W-3:0] r_word_off;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_wdata;
  logic              r_wr_hit;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-3:0] w_lk;
  logic              w_word;
  logic [SET_BITS-1:0] w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_way_hit;
  logic              w_hit;
  logic              w_hit_w;
  logic              w_victim;
  logic [63:0]       w_hit_line;
  logic [31:0]       w_hit_word;
  logic [31:0]       w_fill_word;
  logic              w_accept;
  logic              w_rd_hit;
  logic              w_fill_done;
  logic              w_wr_done;
  logic              w_cnt_hit;
  logic              w_cnt_miss;

  // Lookup uses the live address in IDLE and the latched one while the SRAM is busy.
  assign w_off  = address - ADDR_W'(BASE_ADDR);
  assign w_lk   = (r_state == S_IDLE) ? w_off[ADDR_W-1:2] : r_word_off;
  assign w_word = w_lk[0];
  assign w_idx  = w_lk[SET_BITS:1];
  assign w_tag  = w_lk[ADDR_W-3:SET_BITS+1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign w_way_hit[gi] = r_valid[w_idx][gi] && (r_tag[gi][w_idx] == w_tag);
    end
  endgenerate

  assign w_hit       = |w_way_hit;
  assign w_hit_w     = w_way_hit[1];
  assign w_hit_line  = r_data[w_hit_w][w_idx];
  assign w_hit_word  = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
  assign w_fill_word = w_word ? mem_rdata[63:32] : mem_rdata[31:0];
  assign w_victim    = !r_valid[w_idx][0] ? 1'b0 :
                       !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_accept    = (r_state == S_IDLE) && (wr_en || (rd_en && !w_hit));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (wr_en)               w_next = S_WRITE;
        else if (rd_en && !w_hit) w_next = S_FILL;
      end
      S_FILL:  if (mem_ready) w_next = S_IDLE;
      S_WRITE: if (mem_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    read_data   = 32'd0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    w_rd_hit    = 1'b0;
    w_fill_done = 1'b0;
    w_wr_done   = 1'b0;
    w_cnt_hit   = 1'b0;
    w_cnt_miss  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = !(wr_en || (rd_en && !w_hit));
        if (rd_en && !wr_en && w_hit) begin
          read_data = w_hit_word;
          w_rd_hit  = 1'b1;
          w_cnt_hit = 1'b1;
        end
      end
      S_FILL: begin
        mem_rd_en = 1'b1;
        if (mem_ready) begin
          ready       = 1'b1;
          read_data   = w_fill_word;
          w_fill_done = 1'b1;
          w_cnt_miss  = 1'b1;
        end
      end
      S_WRITE: begin
        mem_wr_en = 1'b1;
        if (mem_ready) begin
          ready      = 1'b1;
          w_wr_done  = 1'b1;
          w_cnt_hit  = r_wr_hit;
          w_cnt_miss = !r_wr_hit;
        end
      end
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_word_off <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_wr_hit   <= 1'b0;
    end else if (w_accept) begin
      r_word_off <= w_off[ADDR_W-1:2];
      r_wr_hit   <= w_hit;
      if (wr_en) begin
        r_mem_addr <= 32'(w_off & ~ADDR_W'(3));
        r_wdata    <= write_data;
      end else begin
        r_mem_addr <= 32'(w_off & ~ADDR_W'(7));
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= 2'b00;
      r_lru <= '0;
    end else if (w_fill_done) begin
      r_valid[w_idx][w_victim] <= 1'b1;
      r_lru[w_idx]             <= ~w_victim;
    end else if (w_rd_hit || (w_wr_done && w_hit)) begin
      r_lru[w_idx] <= ~w_hit_w;
    end
  end

  // Tag and data need no reset: valid bits gate every use.
  always_ff @(posedge clock) begin
    if (w_fill_done) begin
      r_tag[w_victim][w_idx]  <= w_tag;
      r_data[w_victim][w_idx] <= mem_rdata;
    end else if (w_wr_done && w_hit) begin
      if (w_word) r_data[w_hit_w][w_idx][63:32] <= r_wdata;
      else        r_data[w_hit_w][w_idx][31:0]  <= r_wdata;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_cnt_hit && (r_hit_count != '1))   r_hit_count  <= r_hit_count + 1'b1;
      if (w_cnt_miss && (r_miss_count != '1)) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_arm_dcache.sv
// Scoreboard bench for arm_dcache: directed loads/stores with a driver that
// answers SRAM requests and a monitor that checks each completed request.
module tb_arm_dcache;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_ready = 1'b0;
  logic [3:0]  hit_count;
  logic [3:0]  miss_count;

  arm_dcache #(.SET_BITS(6), .ADDR_W(32), .BASE_ADDR(1024), .CNT_W(4)) dut (
    .clock(clock), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          wr;
    bit          hit;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] L1 = 64'h22222222_11111111;
  localparam logic [63:0] L2 = 64'h44444444_33333333;
  localparam logic [63:0] L3 = 64'h66666666_55555555;
  localparam logic [63:0] L4 = 64'hBBBBBBBB_AAAAAAAA;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: records SRAM-side activity per request and checks on completion.
  initial begin
    bit          seen_rd;
    bit          seen_wr;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    int          wait_cyc;
    exp_t        e;
    seen_rd = 0; seen_wr = 0; seen_addr = 0; seen_wdata = 0; wait_cyc = 0;
    forever begin
      @(negedge clock);
      if (rst) begin
        seen_rd = 0; seen_wr = 0; wait_cyc = 0;
      end else begin
        if (mem_rd_en && mem_wr_en) check("mem_en_exclusive", 32'd1, 32'd0);
        if (rd_en || wr_en) begin
          if (mem_rd_en) begin seen_rd = 1; seen_addr = mem_addr; end
          if (mem_wr_en) begin seen_wr = 1; seen_addr = mem_addr; seen_wdata = mem_wdata; end
          if (ready) begin
            if (sb.size() == 0) begin
              check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              if (e.wr) begin
                check("wr_mem_wr_en", 32'(seen_wr), 32'd1);
                check("wr_no_mem_rd", 32'(seen_rd), 32'd0);
                check("wr_mem_addr", seen_addr, e.maddr);
                check("wr_mem_wdata", seen_wdata, e.wdata);
              end else begin
                check("rd_data", read_data, e.rdata);
                if (e.hit) begin
                  check("rd_hit_latency", 32'(wait_cyc), 32'd0);
                  check("rd_hit_no_fill", 32'(seen_rd), 32'd0);
                end else begin
                  check("rd_miss_fill", 32'(seen_rd), 32'd1);
                  check("rd_fill_addr", seen_addr, e.maddr);
                end
              end
              $display("xact %s addr=%0d hit=%0d data=%h cycles=%0d",
                       e.wr ? "WR" : "RD", address, e.hit, read_data, wait_cyc);
            end
            seen_rd = 0; seen_wr = 0; wait_cyc = 0;
          end else begin
            wait_cyc++;
          end
        end
      end
    end
  end

  // Driver: holds the request until ready; answers SRAM requests after 2 cycles.
  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [63:0] line, input bit hit,
                      input logic [31:0] rdata, input logic [31:0] maddr);
    exp_t e;
    int   n;
    bit   done;
    e.wr = wr; e.hit = hit; e.rdata = rdata; e.maddr = maddr; e.wdata = wd;
    sb.push_back(e);
    rd_en = !wr; wr_en = wr; address = a; write_data = wd; mem_rdata = line;
    mem_ready = 1'b0;
    n = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (ready) done = 1;
      else if (mem_rd_en || mem_wr_en) n++;
      @(posedge clock);
      #1;
      mem_ready = (!done && n == 2);
    end
    if (!done) begin
      check("xact_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    rd_en = 1'b0; wr_en = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    @(posedge clock); #1 rst = 1'b0;

    // Cold read then same-line hit
    xact(0, 1024, 0, L1, 0, 32'h11111111, 0);
    xact(0, 1028, 0, 0,  1, 32'h22222222, 0);
    check("cnt_hit_a", 32'(hit_count), 32'd1);
    check("cnt_miss_a", 32'(miss_count), 32'd1);

    // Write hit then read back
    xact(1, 1024, 32'hDEADBEEF, 0, 1, 0, 0);
    xact(0, 1024, 0, 0, 1, 32'hDEADBEEF, 0);

    // LRU eviction in set 0
    xact(0, 1536, 0, L2, 0, 32'h33333333, 512);
    xact(0, 1024, 0, 0,  1, 32'hDEADBEEF, 0);
    xact(0, 2048, 0, L3, 0, 32'h55555555, 1024);
    xact(0, 1024, 0, 0,  1, 32'hDEADBEEF, 0);
    xact(0, 1536, 0, L2, 0, 32'h33333333, 512);

    // No-write-allocate
    xact(1, 3000, 32'hCAFEF00D, 0, 0, 0, 1976);
    xact(0, 3000, 0, L4, 0, 32'hAAAAAAAA, 1976);
    xact(0, 3004, 0, 0,  1, 32'hBBBBBBBB, 0);
    check("cnt_hit_b", 32'(hit_count), 32'd6);
    check("cnt_miss_b", 32'(miss_count), 32'd6);

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    @(negedge clock);
    check("idle_mr_ready", 32'(ready), 32'd1);
    @(posedge clock); #1 mem_ready = 1'b0;
    @(negedge clock);
    check("idle_mr_no_rd", 32'(mem_rd_en), 32'd0);
    check("idle_mr_no_wr", 32'(mem_wr_en), 32'd0);

    // Reset in the middle of a fill
    @(posedge clock); #1 rd_en = 1'b1; address = 4096;
    @(posedge clock); #1;
    @(negedge clock);
    check("fill_started", 32'(mem_rd_en), 32'd1);
    #2 rst = 1'b1; rd_en = 1'b0;
    #1;
    check("rst_fill_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_fill_ready", 32'(ready), 32'd1);
    @(posedge clock); #1 rst = 1'b0;
    check("rst_fill_hits", 32'(hit_count), 32'd0);
    xact(0, 1024, 0, L1, 0, 32'h11111111, 0);
    check("post_rst_miss", 32'(miss_count), 32'd1);

    // Hit counter saturation
    for (int i = 0; i < 15; i++) xact(0, 1028, 0, 0, 1, 32'h22222222, 0);
    check("sat_reach", 32'(hit_count), 32'd15);
    for (int i = 0; i < 5; i++) xact(0, 1028, 0, 0, 1, 32'h22222222, 0);
    check("sat_hold", 32'(hit_count), 32'd15);
    check("sat_miss", 32'(miss_count), 32'd1);

    @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
